// File: rtl/incline_disp_pkg.sv
// Shared display-mode type and LED pattern helpers for the incline display back-end.
package incline_disp_pkg;

  typedef enum logic [1:0] {
    RAW = 2'd0,
    DOT = 2'd1,
    BAR = 2'd2,
    AUX = 2'd3
  } disp_mode_t;

  // Helpers return the widest supported pattern; callers keep the low LED_W bits.
  localparam int LED_MAX = 256;
  localparam int IDX_MAX_W = 8;

  function automatic logic [LED_MAX-1:0] onehot(input logic [IDX_MAX_W-1:0] idx);
    onehot = LED_MAX'(1) << idx;
  endfunction

  // Bits 0..idx set; at idx=LED_MAX-1 the shift wraps to zero and the subtract yields all ones.
  function automatic logic [LED_MAX-1:0] therm(input logic [IDX_MAX_W-1:0] idx);
    therm = (LED_MAX'(2) << idx) - LED_MAX'(1);
  endfunction

endpackage

// File: rtl/incline_led_disp_if.sv
// Sample, control and display signals between the incline source and the LED back-end.
interface incline_led_disp_if
  import incline_disp_pkg::*;
#(
  parameter int IN_W  = 13,
  parameter int LED_W = 8
);
  logic                    vld;
  logic signed [IN_W-1:0]  incline;
  disp_mode_t              mode;
  logic                    peak_clr;
  logic [LED_W-1:0]        LED;
  logic                    avg_vld;
  logic signed [IN_W-1:0]  avg;
  logic                    stale;

  modport master (
    output vld, incline, mode, peak_clr,
    input  LED, avg_vld, avg, stale
  );

  modport slave (
    input  vld, incline, mode, peak_clr,
    output LED, avg_vld, avg, stale
  );
endinterface

// File: rtl/incline_avg.sv
// Block averager: sums 2^AVG_LOG2 signed samples and emits floor(sum / 2^AVG_LOG2).
module incline_avg #(
  parameter int IN_W     = 13,
  parameter int AVG_LOG2 = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   vld,
  input  logic signed [IN_W-1:0] incline,
  output logic signed [IN_W-1:0] avg,
  output logic                   avg_vld
);

  generate
    if (AVG_LOG2 == 0) begin : g_pass
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          avg     <= '0;
          avg_vld <= 1'b0;
        end else begin
          avg_vld <= vld;
          if (vld) avg <= incline;
        end
      end
    end else begin : g_acc
      localparam int ACC_W = IN_W + AVG_LOG2;

      logic signed [ACC_W-1:0] acc;
      logic signed [ACC_W-1:0] sum;
      logic signed [IN_W-1:0]  sum_sh;
      logic [AVG_LOG2-1:0]     cnt;

      // Accumulator is wide enough for a full window, so the sum never wraps.
      assign sum    = acc + ACC_W'(incline);
      assign sum_sh = IN_W'(sum >>> AVG_LOG2);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          acc     <= '0;
          cnt     <= '0;
          avg     <= '0;
          avg_vld <= 1'b0;
        end else begin
          avg_vld <= 1'b0;
          if (vld) begin
            if (cnt == '1) begin
              avg     <= sum_sh;
              acc     <= '0;
              cnt     <= '0;
              avg_vld <= 1'b1;
            end else begin
              acc <= sum;
              cnt <= cnt + 1'b1;
            end
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/incline_led_disp.sv
// Incline LED display: averaging, staleness watchdog and mode mux.
// Optional peak hold on AUX mode is built when PEAK_HOLD_EN is defined.
module incline_led_disp
  import incline_disp_pkg::*;
#(
  parameter int IN_W      = 13,
  parameter int LED_W     = 8,
  parameter int SHIFT     = 1,
  parameter int AVG_LOG2  = 2,
  parameter int STALE_CYC = 25_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  incline_led_disp_if.slave  bus
);

  localparam int IDX_W = $clog2(LED_W);
  localparam int SC_W  = $clog2(STALE_CYC + 1);

  logic signed [IN_W-1:0] avg;
  logic                   avg_vld;
  logic [SC_W-1:0]        stale_cnt;
  logic                   stale;
  logic [IDX_W-1:0]       idx;
  logic [LED_W-1:0]       aux_pat;
  logic [LED_W-1:0]       led_reg;
  logic [LED_W-1:0]       led_next;
  logic [LED_MAX-1:0]     oh_full;
  logic [LED_MAX-1:0]     th_full;

  incline_avg #(
    .IN_W     (IN_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld     (bus.vld),
    .incline (bus.incline),
    .avg     (avg),
    .avg_vld (avg_vld)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)            stale_cnt <= '0;
    else if (bus.vld)      stale_cnt <= '0;
    else if (!stale)       stale_cnt <= stale_cnt + 1'b1;
  end

  assign stale = (stale_cnt == SC_W'(STALE_CYC));

  // Top bits of the signed average, MSB flipped to give offset binary 0..LED_W-1.
  assign idx = avg[IN_W-1 -: IDX_W] ^ IDX_W'(1 << (IDX_W - 1));

`ifdef PEAK_HOLD_EN
  logic [IDX_W-1:0]   peak;
  logic [LED_MAX-1:0] peak_full;

  always_ff @(posedge clk) begin
    if (!rst_n)                      peak <= '0;
    else if (bus.peak_clr)           peak <= idx;
    else if (avg_vld && idx > peak)  peak <= idx;
  end

  assign peak_full = therm(IDX_MAX_W'(peak));
  assign aux_pat   = peak_full[LED_W-1:0];
`else
  assign aux_pat = '1;
`endif

  always_comb begin
    led_next = '0;
    oh_full  = onehot(IDX_MAX_W'(idx));
    th_full  = therm(IDX_MAX_W'(idx));
    case (bus.mode)
      RAW: led_next = avg[SHIFT+LED_W-1:SHIFT];
      DOT: led_next = oh_full[LED_W-1:0];
      BAR: led_next = th_full[LED_W-1:0];
      AUX: led_next = aux_pat;
      default: led_next = '0;
    endcase
    if (stale) led_next = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) led_reg <= '0;
    else        led_reg <= led_next;
  end

  assign bus.LED     = led_reg;
  assign bus.avg     = avg;
  assign bus.avg_vld = avg_vld;
  assign bus.stale   = stale;

endmodule
